// File: rtl/fifo_splitter_n_pkg.sv
// -----------------------------------------------------------------------------
// fifo_splitter_n_pkg
// Shared sizing helpers for the N-way stream splitter and its per-channel FIFO.
//   count_width(depth) : bits needed to hold an occupancy of 0..depth
//   ptr_width(depth)   : bits of a read/write pointer into a depth-entry array
// Both are constant functions, so they can size ports and localparams.
// -----------------------------------------------------------------------------
package fifo_splitter_n_pkg;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // DEPTH is a power of two, so a $clog2(DEPTH)-bit pointer wraps for free.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_splitter_n_channel.sv
// -----------------------------------------------------------------------------
// fifo_fwft_channel
// First-word-fall-through FIFO used once per splitter output.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   push, din         : write request and word (ignored when full or in reset)
//   pop               : remove head (ignored when empty)
//   dout              : head word, combinational from the array; 0 when empty
//   empty, full       : occupancy flags, derived from the registered count
//   count             : occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module fifo_fwft_channel
    import fifo_splitter_n_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    localparam int CW        = count_width(DEPTH),
    localparam int PW        = ptr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  full,
    output logic [CW-1:0]         count
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push & ~full & ~rst;
    assign do_pop  = pop & ~empty;

    // The storage array carries no reset; only pointers and count do.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Gating by empty keeps the output at zero after reset without clearing
    // the array; the head is presented straight from storage otherwise.
    assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fifo_splitter_n.sv
// -----------------------------------------------------------------------------
// fifo_splitter_n
// N-way fan-out of a valid/ready stream. Each accepted word is copied into the
// FIFO of every channel selected by data_in_mask; every channel drains on its
// own handshake, so one stalled consumer only blocks once its FIFO is full.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   data_in         : input word
//   data_in_valid   : input word valid
//   data_in_mask    : destination mask, bit i routes the word to channel i
//   data_in_ready   : word can be accepted (depends on full flags and mask only)
//   data_out        : channel i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   data_out_valid  : per-channel valid (FIFO not empty)
//   data_out_ready  : per-channel consumer ready
//   fifo_count      : channel i occupancy at [i*CW +: CW]
// -----------------------------------------------------------------------------
module fifo_splitter_n
    import fifo_splitter_n_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_OUTPUTS = 2,
    parameter int DEPTH       = 4,
    localparam int CW         = count_width(DEPTH)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_WIDTH-1:0]             data_in,
    input  logic                              data_in_valid,
    input  logic [NUM_OUTPUTS-1:0]            data_in_mask,
    output logic                              data_in_ready,
    output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] data_out,
    output logic [NUM_OUTPUTS-1:0]            data_out_valid,
    input  logic [NUM_OUTPUTS-1:0]            data_out_ready,
    output logic [NUM_OUTPUTS*CW-1:0]         fifo_count
);

    logic [NUM_OUTPUTS-1:0] full;
    logic [NUM_OUTPUTS-1:0] empty;
    logic [NUM_OUTPUTS-1:0] push;
    logic [NUM_OUTPUTS-1:0] pop;
    logic                   accept;

    // A word is taken only if every selected channel has room, so a push is
    // always all-or-nothing. An all-zero mask is accepted and dropped.
    assign data_in_ready  = &(~data_in_mask | ~full);
    assign accept         = data_in_valid & data_in_ready;
    assign push           = accept ? data_in_mask : '0;
    assign data_out_valid = ~empty;
    assign pop            = data_out_ready & ~empty;

    for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_ch
        fifo_fwft_channel #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .push  (push[i]),
            .din   (data_in),
            .pop   (pop[i]),
            .dout  (data_out[i*DATA_WIDTH +: DATA_WIDTH]),
            .empty (empty[i]),
            .full  (full[i]),
            .count (fifo_count[i*CW +: CW])
        );
    end

endmodule
